// File: rtl/memory_controller_if.sv
// ---------------------------------------------------------------------------
// memory_controller_if
// Bundles the data-cache, instruction-cache and RAM signals of the memory
// controller.
//
// Handshake semantics:
//   - Data side: d_vis_signal != NOP means a beat is requested in that cycle.
//     Read data is valid combinationally in the same cycle. A write is
//     committed at the rising edge that ends the cycle. A burst ends with the
//     first NOP.
//   - Instruction side: i_vis_signal = READ is held as a level until
//     i_mem_status = FINISHED is seen. i_mem_data is valid only while
//     FINISHED is shown.
//   - RAM side: ram_rdata follows ram_addr combinationally. ram_we commits
//     ram_wdata at the rising edge.
//
// Modports:
//   slave  - controller view (inputs from the caches and RAM, outputs to them)
//   master - environment view (the caches and RAM)
// ---------------------------------------------------------------------------
interface memory_controller_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int LEN        = 32
);
    logic [ADDR_WIDTH-1:0] d_vis_addr;
    logic [1:0]            d_vis_signal;
    logic [LEN-1:0]        d_writen_data;
    logic [LEN-1:0]        d_mem_data;
    logic [1:0]            d_mem_status;
    logic [ADDR_WIDTH-1:0] i_vis_addr;
    logic [1:0]            i_vis_signal;
    logic [LEN-1:0]        i_mem_data;
    logic [1:0]            i_mem_status;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [LEN-1:0]        ram_wdata;
    logic                  ram_we;
    logic [LEN-1:0]        ram_rdata;

    modport slave (
        input  d_vis_addr, d_vis_signal, d_writen_data,
        input  i_vis_addr, i_vis_signal, ram_rdata,
        output d_mem_data, d_mem_status, i_mem_data, i_mem_status,
        output ram_addr, ram_wdata, ram_we
    );

    modport master (
        output d_vis_addr, d_vis_signal, d_writen_data,
        output i_vis_addr, i_vis_signal, ram_rdata,
        input  d_mem_data, d_mem_status, i_mem_data, i_mem_status,
        input  ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/memory_controller.sv
// ---------------------------------------------------------------------------
// memory_controller
// Arbitrates one combinational-read RAM port between the data cache (absolute
// priority) and the instruction cache.
//   - Data bursts arrive as repeated beats at a constant start address. They
//     are turned into incrementing word addresses.
//   - Instruction fetches are single-word and use a registered handshake.
//
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous active-high reset
//   bus         - memory_controller_if.slave: cache request and response
//                 signals, plus the RAM port
//   o_dbg_state - current FSM state (IDLE=0, D_BURST=1, I_SERVE=2, I_DONE=3)
// ---------------------------------------------------------------------------
module memory_controller #(
    parameter int ADDR_WIDTH  = 17,
    parameter int LEN         = 32,
    parameter int VECTOR_SIZE = 8,
    parameter int BEAT_WIDTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    memory_controller_if.slave  bus,
    output logic [1:0]          o_dbg_state
);
    localparam logic [1:0] MEM_NOP        = 2'd0;
    localparam logic [1:0] MEM_READ       = 2'd1;
    localparam logic [1:0] MEM_WRITE      = 2'd2;
    localparam logic [1:0] MEM_READ_BURST = 2'd3;

    localparam logic [1:0] MEM_RESTING  = 2'd0;
    localparam logic [1:0] MEM_WORKING  = 2'd1;
    localparam logic [1:0] MEM_FINISHED = 2'd2;

    localparam logic [BEAT_WIDTH-1:0] VEC_LIMIT = BEAT_WIDTH'(VECTOR_SIZE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_D_BURST = 2'd1,
        S_I_SERVE = 2'd2,
        S_I_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [BEAT_WIDTH-1:0] r_beat;
    logic [ADDR_WIDTH-1:0] r_i_addr;
    logic [LEN-1:0]        r_i_mem_data;
    logic [1:0]            r_i_mem_status;

    state_t                w_state_nxt;
    logic [BEAT_WIDTH-1:0] w_beat_nxt;
    logic [ADDR_WIDTH-1:0] w_i_addr_nxt;
    logic [LEN-1:0]        w_i_data_nxt;
    logic [1:0]            w_i_status_nxt;

    logic                  w_d_active;
    logic [BEAT_WIDTH-1:0] w_beat_eff;
    logic [ADDR_WIDTH-1:0] w_beat_off;
    logic [ADDR_WIDTH-1:0] w_ea;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [LEN-1:0]        w_ram_wdata;
    logic                  w_ram_we;
    logic [LEN-1:0]        w_d_mem_data;

    assign w_d_active = (bus.d_vis_signal != MEM_NOP);

    // A data beat that preempts a fetch always starts a fresh burst at beat 0.
    assign w_beat_eff = (r_state == S_I_SERVE) ? '0 : r_beat;

    // The byte offset is beat*4. The sum wraps modulo 2^ADDR_WIDTH.
    assign w_beat_off = {{(ADDR_WIDTH-BEAT_WIDTH-2){1'b0}}, w_beat_eff, 2'b00};
    assign w_ea       = bus.d_vis_addr + w_beat_off;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_beat         <= '0;
            r_i_addr       <= '0;
            r_i_mem_data   <= '0;
            r_i_mem_status <= MEM_RESTING;
        end else begin
            r_state        <= w_state_nxt;
            r_beat         <= w_beat_nxt;
            r_i_addr       <= w_i_addr_nxt;
            r_i_mem_data   <= w_i_data_nxt;
            r_i_mem_status <= w_i_status_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_beat_nxt   = r_beat;
        w_i_addr_nxt = r_i_addr;
        w_i_data_nxt = r_i_mem_data;
        // A held fetch request that is not being finished reads as WORKING.
        w_i_status_nxt = (bus.i_vis_signal == MEM_READ) ? MEM_WORKING : MEM_RESTING;
        w_ram_addr   = '0;
        w_ram_wdata  = '0;
        w_ram_we     = 1'b0;
        w_d_mem_data = '0;

        if (w_d_active) begin
            // A data beat is served in every state, with absolute priority.
            w_ram_addr = w_ea;
            case (bus.d_vis_signal)
                MEM_READ, MEM_READ_BURST: w_d_mem_data = bus.ram_rdata;
                MEM_WRITE: begin
                    // Write beats past the vector length are dropped.
                    if (w_beat_eff < VEC_LIMIT) begin
                        w_ram_we    = 1'b1;
                        w_ram_wdata = bus.d_writen_data;
                    end
                end
                default: ;
            endcase
            w_beat_nxt  = (&w_beat_eff) ? w_beat_eff : w_beat_eff + BEAT_WIDTH'(1);
            w_state_nxt = S_D_BURST;
            if (r_state == S_I_DONE) begin
                w_i_status_nxt = MEM_RESTING;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_vis_signal == MEM_READ) begin
                        w_i_addr_nxt = bus.i_vis_addr;
                        w_state_nxt  = S_I_SERVE;
                    end
                end
                S_D_BURST: begin
                    w_beat_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end
                S_I_SERVE: begin
                    w_ram_addr     = r_i_addr;
                    w_i_data_nxt   = bus.ram_rdata;
                    w_i_status_nxt = MEM_FINISHED;
                    w_state_nxt    = S_I_DONE;
                end
                S_I_DONE: begin
                    // Ignore the still-held request for one cycle so it is
                    // not served twice.
                    w_i_status_nxt = MEM_RESTING;
                    w_state_nxt    = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign bus.ram_addr     = w_ram_addr;
    assign bus.ram_wdata    = w_ram_wdata;
    assign bus.ram_we       = w_ram_we & ~rst;
    assign bus.d_mem_data   = w_d_mem_data;
    assign bus.d_mem_status = ((r_state == S_I_SERVE) || (r_state == S_D_BURST)) ?
                              MEM_WORKING : MEM_RESTING;
    assign bus.i_mem_data   = r_i_mem_data;
    assign bus.i_mem_status = r_i_mem_status;
    assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_memory_controller.sv
`timescale 1ns/1ps
module tb_memory_controller;
  localparam int AW = 17;
  localparam int DW = 32;
  localparam logic [1:0] NOP = 2'd0, RD = 2'd1, WR = 2'd2, RB = 2'd3;
  localparam logic [1:0] RESTING = 2'd0, WORKING = 2'd1, FINISHED = 2'd2;
  localparam logic [1:0] ST_IDLE = 2'd0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  memory_controller_if #(.ADDR_WIDTH(AW), .LEN(DW)) bus ();

  memory_controller #(.ADDR_WIDTH(AW), .LEN(DW), .VECTOR_SIZE(8), .BEAT_WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  // RAM: combinational read; writes are committed by advance() at the edge.
  logic [DW-1:0] mem [0:32767];
  logic [DW-1:0] ref_mem [0:32767];
  assign bus.ram_rdata = mem[bus.ram_addr[AW-1:2]];

  int n_checks = 0;
  int n_fail = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    return {17'h0, a[AW-1:2]} ^ 32'h5A5A0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_d(input logic [1:0] sig, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.d_vis_signal  = sig;
    bus.d_vis_addr    = addr;
    bus.d_writen_data = data;
  endtask

  task automatic drive_i(input logic [1:0] sig, input logic [AW-1:0] addr);
    bus.i_vis_signal = sig;
    bus.i_vis_addr   = addr;
  endtask

  // Called at the negedge: capture the write seen this cycle, step to the
  // next cycle and commit it to the RAM.
  task automatic advance();
    logic cw;
    logic [14:0] ci;
    logic [DW-1:0] cd;
    cw = bus.ram_we;
    ci = bus.ram_addr[AW-1:2];
    cd = bus.ram_wdata;
    @(posedge clk);
    #1;
    if (cw) mem[ci] = cd;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]    sig;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_dmem;
    logic [1:0]    exp_dstat_next;
  } vec_t;

  vec_t vecs [7];

  // ---------------- random-phase model state ----------------
  int n_beat;
  bit prev_act;
  logic [1:0] cur_sig, sig;
  logic [AW-1:0] cur_addr, ea;
  logic [DW-1:0] wdata;
  int burst_rem, gap_rem, eb;
  bit i_out, i_drop;
  logic [AW-1:0] i_addr_t;
  int i_wait;
  int fin_count, fin_cycle;

  initial begin
    for (int w = 0; w < 32768; w++) begin
      mem[w] = pattern(AW'(w << 2));
      ref_mem[w] = 32'h0;
    end
    rst = 1'b1;
    drive_d(NOP, '0, '0);
    drive_i(NOP, '0);

    // ---- reset ----
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) begin
        check("rst_ram_we_held", bus.ram_we, 0);
        check("rst_state_held", dbg_state, ST_IDLE);
      end
      advance();
    end
    rst = 1'b0;
    @(negedge clk);
    check("rst_d_status", bus.d_mem_status, RESTING);
    check("rst_i_status", bus.i_mem_status, RESTING);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_i_data", bus.i_mem_data, 0);
    advance();

    // ---- table-driven single beats ----
    vecs[0] = '{RD, 17'h00004, 32'h0, 1'b0, 17'h00004, pattern(17'h00004), WORKING};
    vecs[1] = '{RB, 17'h1FFFC, 32'h0, 1'b0, 17'h1FFFC, pattern(17'h1FFFC), WORKING};
    vecs[2] = '{WR, 17'h00800, 32'hCAFE0001, 1'b1, 17'h00800, 32'h0, WORKING};
    vecs[3] = '{RD, 17'h00800, 32'h0, 1'b0, 17'h00800, 32'hCAFE0001, WORKING};
    vecs[4] = '{NOP, 17'h00123, 32'h77, 1'b0, 17'h00000, 32'h0, RESTING};
    vecs[5] = '{WR, 17'h1FFF8, 32'h0BADF00D, 1'b1, 17'h1FFF8, 32'h0, WORKING};
    vecs[6] = '{RB, 17'h1FFF8, 32'h0, 1'b0, 17'h1FFF8, 32'h0BADF00D, WORKING};
    for (int v = 0; v < 7; v++) begin
      drive_d(vecs[v].sig, vecs[v].addr, vecs[v].wdata);
      @(negedge clk);
      check($sformatf("vec%0d_ram_addr", v), bus.ram_addr, vecs[v].exp_addr);
      check($sformatf("vec%0d_ram_we", v), bus.ram_we, vecs[v].exp_we);
      check($sformatf("vec%0d_d_data", v), bus.d_mem_data, vecs[v].exp_dmem);
      check($sformatf("vec%0d_d_status", v), bus.d_mem_status, RESTING);
      if (vecs[v].exp_we) check($sformatf("vec%0d_wdata", v), bus.ram_wdata, vecs[v].wdata);
      advance();
      drive_d(NOP, '0, '0);
      @(negedge clk);
      check($sformatf("vec%0d_d_status_next", v), bus.d_mem_status, vecs[v].exp_dstat_next);
      check($sformatf("vec%0d_idle_addr", v), bus.ram_addr, 0);
      advance();
    end

    // ---- data load burst ----
    for (int n = 0; n < 9; n++) mem[(32'h100 >> 2) + n] = 32'h10 + n;
    for (int n = 0; n < 9; n++) begin
      drive_d(RB, 17'h100, '0);
      @(negedge clk);
      check($sformatf("load_addr%0d", n), bus.ram_addr, 17'h100 + 4 * n);
      check($sformatf("load_data%0d", n), bus.d_mem_data, 32'h10 + n);
      if (n > 0) check($sformatf("load_status%0d", n), bus.d_mem_status, WORKING);
      advance();
    end
    drive_d(NOP, '0, '0);
    @(negedge clk);
    check("load_nop_data", bus.d_mem_data, 0);
    advance();
    @(negedge clk);
    check("load_end_state", dbg_state, ST_IDLE);
    check("load_end_status", bus.d_mem_status, RESTING);
    advance();

    // ---- data store burst ----
    mem[32'h220 >> 2] = 32'h12345678;
    for (int n = 0; n < 9; n++) begin
      drive_d(WR, 17'h200, 32'hA0 + n);
      @(negedge clk);
      check($sformatf("store_addr%0d", n), bus.ram_addr, 17'h200 + 4 * n);
      check($sformatf("store_we%0d", n), bus.ram_we, (n < 8) ? 1 : 0);
      advance();
    end
    drive_d(NOP, '0, '0);
    @(negedge clk);
    advance();
    for (int n = 0; n < 8; n++) check($sformatf("store_mem%0d", n), mem[(32'h200 >> 2) + n], 32'hA0 + n);
    check("store_9th_dropped", mem[32'h220 >> 2], 32'h12345678);

    // ---- instruction fetch ----
    mem[32'h40 >> 2] = 32'hDEADBEEF;
    fin_count = 0;
    drive_i(RD, 17'h40);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.i_mem_status == FINISHED) fin_count++;
      if (c == 0) check("fetch_c0_status", bus.i_mem_status, RESTING);
      if (c == 1) begin
        check("fetch_c1_status", bus.i_mem_status, WORKING);
        check("fetch_c1_addr", bus.ram_addr, 17'h40);
        check("fetch_c1_d_status", bus.d_mem_status, WORKING);
      end
      if (c == 2) begin
        check("fetch_c2_status", bus.i_mem_status, FINISHED);
        check("fetch_c2_data", bus.i_mem_data, 32'hDEADBEEF);
      end
      if (c == 3) check("fetch_c3_status", bus.i_mem_status, RESTING);
      advance();
      if (c == 2) drive_i(NOP, '0);
    end
    check("fetch_one_pulse", fin_count, 1);

    // ---- preemption ----
    drive_i(RD, 17'h40);
    @(negedge clk);
    advance();
    for (int n = 0; n < 3; n++) begin
      drive_d(RB, 17'h100, '0);
      @(negedge clk);
      check($sformatf("preempt_data%0d", n), bus.d_mem_data, 32'h10 + n);
      check($sformatf("preempt_addr%0d", n), bus.ram_addr, 17'h100 + 4 * n);
      check($sformatf("preempt_istat%0d", n), bus.i_mem_status, WORKING);
      if (n == 0) check("preempt_d_status", bus.d_mem_status, WORKING);
      advance();
    end
    drive_d(NOP, '0, '0);
    fin_cycle = -1;
    for (int c = 4; c < 14 && fin_cycle < 0; c++) begin
      @(negedge clk);
      if (bus.i_mem_status == FINISHED) begin
        fin_cycle = c;
        check("preempt_fetch_data", bus.i_mem_data, 32'hDEADBEEF);
      end
      advance();
      if (fin_cycle >= 0) drive_i(NOP, '0);
    end
    check("preempt_finish_cycle", fin_cycle, 7);
    @(negedge clk);
    advance();

    // ---- reset mid-burst ----
    for (int n = 0; n < 3; n++) begin
      drive_d(WR, 17'h280, 32'hC0 + n);
      @(negedge clk);
      advance();
    end
    drive_d(WR, 17'h280, 32'hC3);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_we", bus.ram_we, 0);
    check("midrst_state", dbg_state, ST_IDLE);
    advance();
    rst = 1'b0;
    drive_d(NOP, '0, '0);
    @(negedge clk);
    advance();
    for (int n = 0; n < 2; n++) begin
      drive_d(WR, 17'h300, 32'hB0 + n);
      @(negedge clk);
      check($sformatf("postrst_addr%0d", n), bus.ram_addr, 17'h300 + 4 * n);
      check($sformatf("postrst_we%0d", n), bus.ram_we, 1);
      advance();
    end
    drive_d(NOP, '0, '0);
    @(negedge clk);
    advance();
    check("postrst_mem0", mem[32'h300 >> 2], 32'hB0);
    check("postrst_mem1", mem[32'h304 >> 2], 32'hB1);
    check("midrst_beat3_dropped", mem[32'h28C >> 2], pattern(17'h28C));
    check("midrst_beat2_kept", mem[32'h288 >> 2], 32'hC2);

    // ---- randomized phase against reference model ----
    for (int w = 0; w < 32768; w++) ref_mem[w] = mem[w];
    n_beat = 0; prev_act = 0; burst_rem = 0; gap_rem = 0;
    cur_sig = NOP; cur_addr = '0; i_out = 0; i_drop = 0; i_addr_t = '0; i_wait = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      wdata = $urandom;
      if (burst_rem > 0) begin
        burst_rem--;
        if ($urandom_range(0, 7) == 0) cur_sig = 2'($urandom_range(1, 3));
        sig = cur_sig;
      end else if (gap_rem > 0) begin
        gap_rem--;
        sig = NOP;
      end else if (i_out && i_wait > 30) begin
        gap_rem = 3;
        sig = NOP;
      end else begin
        cur_sig = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) cur_addr = 17'h1FFC0 + AW'($urandom_range(0, 15) << 2);
        else cur_addr = {15'($urandom_range(0, 32767)), 2'b00};
        burst_rem = $urandom_range(1, 18) - 1;
        gap_rem = $urandom_range(1, 6);
        sig = cur_sig;
      end
      drive_d(sig, cur_addr, wdata);

      if (i_drop) begin
        i_drop = 0;
        i_out = 0;
      end else if (!i_out && $urandom_range(0, 3) == 0) begin
        i_out = 1;
        i_wait = 0;
        i_addr_t = {15'($urandom_range(0, 32767)), 2'b00};
      end
      drive_i(i_out ? RD : NOP, i_addr_t);

      @(negedge clk);
      eb = (n_beat > 15) ? 15 : n_beat;
      ea = cur_addr + AW'(eb * 4);
      if (sig != NOP) begin
        check("rnd_ram_addr", bus.ram_addr, ea);
        if (sig == WR) begin
          check("rnd_ram_we", bus.ram_we, (n_beat < 8) ? 1 : 0);
          if (n_beat < 8) check("rnd_wdata", bus.ram_wdata, wdata);
        end else begin
          check("rnd_d_data", bus.d_mem_data, ref_mem[ea[AW-1:2]]);
        end
      end else begin
        check("rnd_idle_we", bus.ram_we, 0);
      end
      if (prev_act) check("rnd_d_status", bus.d_mem_status, WORKING);
      if (bus.i_mem_status == FINISHED) begin
        check("rnd_fetch_pending", (i_out && !i_drop) ? 1 : 0, 1);
        check("rnd_fetch_data", bus.i_mem_data, ref_mem[i_addr_t[AW-1:2]]);
        i_drop = 1;
      end else if (i_out && !i_drop) begin
        i_wait++;
        if (i_wait > 400) begin
          n_checks++;
          n_fail++;
          $display("FAIL rnd_fetch_timeout: no FINISHED after %0d cycles, required within 400", i_wait);
          i_drop = 1;
        end
      end

      if (sig == WR && n_beat < 8) ref_mem[ea[AW-1:2]] = wdata;
      n_beat = (sig != NOP) ? ((n_beat < 15) ? n_beat + 1 : 15) : 0;
      prev_act = (sig != NOP);
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
